// File: rtl/matmul_skew_feeder_if.sv
// Beat input and skewed array-edge bundle for matmul_skew_feeder.
// master = upstream producer, slave = the feeder itself.
interface matmul_skew_feeder_if #(
    parameter int N  = 4,
    parameter int DW = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [N*DW-1:0]   a_vec;
    logic [N*DW-1:0]   b_vec;
    logic [N-1:0]      a_valid_out;
    logic [N*DW-1:0]   a_out;
    logic [N-1:0]      b_valid_out;
    logic [N*DW-1:0]   b_out;

    modport master (
        output in_valid,
        output a_vec,
        output b_vec,
        input  in_ready,
        input  a_valid_out,
        input  a_out,
        input  b_valid_out,
        input  b_out
    );

    modport slave (
        input  in_valid,
        input  a_vec,
        input  b_vec,
        output in_ready,
        output a_valid_out,
        output a_out,
        output b_valid_out,
        output b_out
    );
endinterface

// File: rtl/matmul_skew_feeder.sv
// Diagonal skew feeder and pass sequencer for an N x N systolic matmul array.
// Optional macro FEEDER_STALL_CNT_EN adds a saturating stall_cycles counter port.
module matmul_skew_feeder #(
    parameter int N  = 4,
    parameter int DW = 16,
    parameter int KW = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [KW-1:0]        k_len,
    matmul_skew_feeder_if.slave  bus,
    output logic                 reset_acc,
    output logic                 busy,
    output logic                 done
`ifdef FEEDER_STALL_CNT_EN
    ,
    output logic [15:0]          stall_cycles
`else
`endif
);

    localparam int FW = $clog2(N + 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_STREAM = 3'd2,
        ST_FLUSH  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [KW-1:0]   k_len_q;
    logic [KW-1:0]   k_len_d;
    logic [KW-1:0]   beat_cnt_q;
    logic [KW-1:0]   beat_cnt_d;
    logic [FW-1:0]   flush_cnt_q;
    logic [FW-1:0]   flush_cnt_d;
    logic            reset_acc_q;
    logic            reset_acc_d;
    logic            busy_q;
    logic            busy_d;
    logic            done_q;
    logic            done_d;
    logic            accept_s;

    logic [N-1:0]    a_valid_s;
    logic [N-1:0]    b_valid_s;
    logic [N*DW-1:0] a_out_s;
    logic [N*DW-1:0] b_out_s;

    // in_ready is a pure decode of the state register, so accept never loops back through it.
    assign bus.in_ready = (state_q == ST_STREAM);
    assign accept_s     = bus.in_valid & (state_q == ST_STREAM);

    // Next-state, pass bookkeeping and registered-output decode.
    always_comb begin
        state_d     = state_q;
        k_len_d     = k_len_q;
        beat_cnt_d  = beat_cnt_q;
        flush_cnt_d = flush_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    k_len_d = k_len;
                    state_d = ST_CLEAR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                beat_cnt_d  = {KW{1'b0}};
                flush_cnt_d = {FW{1'b0}};
                if (k_len_q == {KW{1'b0}}) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (accept_s) begin
                    beat_cnt_d = beat_cnt_q + KW'(1);
                    if (beat_cnt_q == (k_len_q - KW'(1))) begin
                        state_d = ST_FLUSH;
                    end else begin
                        state_d = ST_STREAM;
                    end
                end else begin
                    state_d = ST_STREAM;
                end
            end
            ST_FLUSH: begin
                // N cycles is exactly the depth of the longest lane (N registers).
                if (flush_cnt_q == FW'(N - 1)) begin
                    flush_cnt_d = {FW{1'b0}};
                    state_d     = ST_DONE;
                end else begin
                    flush_cnt_d = flush_cnt_q + FW'(1);
                    state_d     = ST_FLUSH;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        reset_acc_d = (state_d == ST_CLEAR);
        busy_d      = (state_d != ST_IDLE);
        done_d      = (state_d == ST_DONE);
    end

    // State, pass counters and control outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            k_len_q     <= {KW{1'b0}};
            beat_cnt_q  <= {KW{1'b0}};
            flush_cnt_q <= {FW{1'b0}};
            reset_acc_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_len_q     <= k_len_d;
            beat_cnt_q  <= beat_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            reset_acc_q <= reset_acc_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign reset_acc = reset_acc_q;
    assign busy      = busy_q;
    assign done      = done_q;

    // Lane i is an (i+1)-deep chain; one valid chain per lane feeds both A and B edges,
    // which keeps a_valid_out and b_valid_out identical by construction.
    for (genvar gi = 0; gi < N; gi++) begin : g_lane
        logic [gi:0]   vld_q;
        logic [gi:0]   vld_d;
        logic [DW-1:0] a_dat_q [0:gi];
        logic [DW-1:0] a_dat_d [0:gi];
        logic [DW-1:0] b_dat_q [0:gi];
        logic [DW-1:0] b_dat_d [0:gi];

        // Stage 0 loads on accept and holds otherwise; later stages shift unconditionally.
        always_comb begin
            vld_d[0] = accept_s;
            if (accept_s) begin
                a_dat_d[0] = bus.a_vec[gi*DW +: DW];
                b_dat_d[0] = bus.b_vec[gi*DW +: DW];
            end else begin
                a_dat_d[0] = a_dat_q[0];
                b_dat_d[0] = b_dat_q[0];
            end
            for (int s = 1; s <= gi; s++) begin
                vld_d[s]   = vld_q[s-1];
                a_dat_d[s] = a_dat_q[s-1];
                b_dat_d[s] = b_dat_q[s-1];
            end
        end

        // Lane register chain.
        always_ff @(posedge clk) begin
            if (rst) begin
                vld_q <= {(gi+1){1'b0}};
                for (int s = 0; s <= gi; s++) begin
                    a_dat_q[s] <= {DW{1'b0}};
                    b_dat_q[s] <= {DW{1'b0}};
                end
            end else begin
                vld_q <= vld_d;
                for (int s = 0; s <= gi; s++) begin
                    a_dat_q[s] <= a_dat_d[s];
                    b_dat_q[s] <= b_dat_d[s];
                end
            end
        end

        assign a_valid_s[gi]          = vld_q[gi];
        assign b_valid_s[gi]          = vld_q[gi];
        assign a_out_s[gi*DW +: DW]   = a_dat_q[gi];
        assign b_out_s[gi*DW +: DW]   = b_dat_q[gi];
    end

    assign bus.a_valid_out = a_valid_s;
    assign bus.b_valid_out = b_valid_s;
    assign bus.a_out       = a_out_s;
    assign bus.b_out       = b_out_s;

`ifdef FEEDER_STALL_CNT_EN
    logic [15:0] stall_q;
    logic [15:0] stall_d;

    // Counts empty STREAM slots; cleared at CLEAR, then held after the pass.
    always_comb begin
        stall_d = stall_q;
        if (state_q == ST_CLEAR) begin
            stall_d = 16'h0000;
        end else if ((state_q == ST_STREAM) && !bus.in_valid && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'h0001;
        end else begin
            stall_d = stall_q;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= 16'h0000;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;
`else
`endif

endmodule

// File: tb/tb_matmul_skew_feeder.sv
// Randomized self-checking bench for matmul_skew_feeder against a pass-schedule
// and beat-history reference model.
module tb_matmul_skew_feeder;

    localparam int N    = 4;
    localparam int DW   = 16;
    localparam int KW   = 8;
    localparam int LW   = N * DW;
    localparam int NCYC = 3000;
    localparam int NEVER = 1 << 30;

    logic          clk;
    logic          rst;
    logic          start;
    logic [KW-1:0] k_len;
    logic          reset_acc;
    logic          busy;
    logic          done;
`ifdef FEEDER_STALL_CNT_EN
    logic [15:0]   stall_cycles;
`endif

    matmul_skew_feeder_if #(.N(N), .DW(DW)) bus_if ();

    matmul_skew_feeder #(.N(N), .DW(DW), .KW(KW)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .k_len        (k_len),
        .bus          (bus_if.slave),
        .reset_acc    (reset_acc),
        .busy         (busy),
        .done         (done)
`ifdef FEEDER_STALL_CNT_EN
        ,
        .stall_cycles (stall_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_errors;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: pass schedule plus the history of what entered stage 0.
    bit          hv [NCYC];
    logic [LW-1:0] ha [NCYC];
    logic [LW-1:0] hb [NCYC];
    logic [LW-1:0] ma, mb;
    bit          m_active;
    int          clear_cyc, done_cyc, beats_left;
    int          m_stall;

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst       = 1'b1;
        start     = 1'b0;
        k_len     = '0;
        bus_if.in_valid = 1'b0;
        bus_if.a_vec    = '0;
        bus_if.b_vec    = '0;
        m_active  = 1'b0;
        clear_cyc = NEVER;
        done_cyc  = NEVER;
        beats_left = 0;
        m_stall   = 0;
        ma = '0;
        mb = '0;

        for (int t = 0; t < NCYC; t++) begin
            logic          e_ready;
            logic [N-1:0]  ev;
            logic [LW-1:0] ea, eb, tmp_a, tmp_b;
            bit            acc;
            int            r;

            @(negedge clk);

            // Expected outputs for this cycle.
            e_ready = m_active && (t > clear_cyc) && (beats_left > 0);
            ev = '0;
            ea = '0;
            eb = '0;
            for (int i = 0; i < N; i++) begin
                int idx;
                idx = t - i - 1;
                if (idx >= 0) begin
                    tmp_a = ha[idx];
                    tmp_b = hb[idx];
                    ev[i] = hv[idx];
                    ea[i*DW +: DW] = tmp_a[i*DW +: DW];
                    eb[i*DW +: DW] = tmp_b[i*DW +: DW];
                end
            end

            chk("reset_acc", 64'(reset_acc), 64'(m_active && (t == clear_cyc)));
            chk("busy",      64'(busy),      64'(m_active));
            chk("done",      64'(done),      64'(m_active && (t == done_cyc)));
            chk("in_ready",  64'(bus_if.in_ready), 64'(e_ready));
            chk("a_valid",   64'(bus_if.a_valid_out), 64'(ev));
            chk("b_valid",   64'(bus_if.b_valid_out), 64'(ev));
            chk("a_out",     64'(bus_if.a_out), 64'(ea));
            chk("b_out",     64'(bus_if.b_out), 64'(eb));
`ifdef FEEDER_STALL_CNT_EN
            chk("stall",     64'(stall_cycles), 64'(m_stall));
`endif

            // Stimulus: directed opening (reset, k=3 full rate, k=0), then random.
            if (t < 3) begin
                rst = 1'b1;
            end else if (t < 60) begin
                rst = 1'b0;
            end else begin
                rst = ($urandom_range(0, 299) == 0);
            end

            if (t == 4) begin
                start = 1'b1;
                k_len = KW'(3);
            end else if (t == 30) begin
                start = 1'b1;
                k_len = KW'(0);
            end else if (t < 60) begin
                start = 1'b0;
                k_len = KW'($urandom_range(0, 6));
            end else begin
                start = m_active ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 3) == 0);
                r = $urandom_range(0, 39);
                k_len = (r == 0) ? KW'(255) : KW'($urandom_range(0, 6));
            end

            bus_if.in_valid = (t < 30) ? 1'b1 : ($urandom_range(0, 3) != 0);
            bus_if.a_vec    = {$urandom(), $urandom()};
            bus_if.b_vec    = {$urandom(), $urandom()};

            // Advance the model by what happens at the coming clock edge.
            if (rst) begin
                m_active   = 1'b0;
                clear_cyc  = NEVER;
                done_cyc   = NEVER;
                beats_left = 0;
                m_stall    = 0;
                ma = '0;
                mb = '0;
                for (int j = 0; j < N; j++) begin
                    if (t - j >= 0) begin
                        hv[t-j] = 1'b0;
                        ha[t-j] = '0;
                        hb[t-j] = '0;
                    end
                end
            end else begin
                acc = e_ready && bus_if.in_valid;
                if (m_active && (t == clear_cyc)) begin
                    m_stall = 0;
                end else if (e_ready && !bus_if.in_valid && (m_stall != 16'hFFFF)) begin
                    m_stall++;
                end
                if (acc) begin
                    ma = bus_if.a_vec;
                    mb = bus_if.b_vec;
                    beats_left--;
                    if (beats_left == 0) begin
                        done_cyc = t + N + 1;
                    end
                end
                hv[t] = acc;
                ha[t] = ma;
                hb[t] = mb;
                if (m_active && (t == done_cyc)) begin
                    m_active  = 1'b0;
                    clear_cyc = NEVER;
                    done_cyc  = NEVER;
                end else if (!m_active && start) begin
                    m_active   = 1'b1;
                    clear_cyc  = t + 1;
                    beats_left = int'(k_len);
                    done_cyc   = (k_len == '0) ? (t + 2) : NEVER;
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
